// File: rtl/dtcm_arbiter_pkg.sv
// Shared constants for the DTCM arbiter: SRAM geometry and requester port indices.
package dtcm_arbiter_pkg;

  localparam int DTCM_RAM_AW = 16;
  localparam int DTCM_RAM_DW = 32;
  localparam int DTCM_RAM_MW = DTCM_RAM_DW / 8;

  localparam logic PORT_LSU = 1'b0;
  localparam logic PORT_EXT = 1'b1;

endpackage

// File: rtl/dtcm_rsp_slot.sv
// Per-port response slot: tracks one outstanding SRAM access and returns its
// data, bypassing SRAM dout on the first cycle and replaying a captured copy
// while the requester stalls.
module dtcm_rsp_slot
  import dtcm_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   grant,
  input  logic                   grant_read,
  input  logic                   rsp_ready,
  input  logic [DTCM_RAM_DW-1:0] ram_dout,
  output logic                   rsp_valid,
  output logic [DTCM_RAM_DW-1:0] rsp_rdata
);

  logic                   rsp_vld_r;
  logic                   fresh_r;
  logic                   is_rd_r;
  logic [DTCM_RAM_DW-1:0] hold_r;
  logic [DTCM_RAM_DW-1:0] rdata_s;

  // Response data: live SRAM output on the cycle after the access, captured copy afterwards.
  always_comb begin
    rdata_s = {DTCM_RAM_DW{1'b0}};
    if (fresh_r) begin
      if (is_rd_r) begin
        rdata_s = ram_dout;
      end else begin
        rdata_s = {DTCM_RAM_DW{1'b0}};
      end
    end else begin
      rdata_s = hold_r;
    end
  end

  // Slot state; a new grant only arrives when the current response leaves this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld_r <= 1'b0;
      fresh_r   <= 1'b0;
      is_rd_r   <= 1'b0;
      hold_r    <= {DTCM_RAM_DW{1'b0}};
    end else if (grant) begin
      rsp_vld_r <= 1'b1;
      fresh_r   <= 1'b1;
      is_rd_r   <= grant_read;
    end else if (rsp_vld_r && !rsp_ready) begin
      if (fresh_r) begin
        hold_r  <= rdata_s;
        fresh_r <= 1'b0;
      end else begin
        fresh_r <= 1'b0;
      end
    end else if (rsp_vld_r) begin
      rsp_vld_r <= 1'b0;
      fresh_r   <= 1'b0;
    end else begin
      fresh_r   <= 1'b0;
    end
  end

  assign rsp_valid = rsp_vld_r;
  assign rsp_rdata = rdata_s;

endmodule

// File: rtl/dtcm_arbiter.sv
// Round-robin arbiter sharing the single-port DTCM SRAM between the LSU and
// the external bus/debug port, with per-port response slots.
module dtcm_arbiter
  import dtcm_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lsu_cmd_valid,
  output logic                   lsu_cmd_ready,
  input  logic                   lsu_cmd_read,
  input  logic [DTCM_RAM_AW-1:0] lsu_cmd_addr,
  input  logic [DTCM_RAM_MW-1:0] lsu_cmd_wmask,
  input  logic [DTCM_RAM_DW-1:0] lsu_cmd_wdata,
  output logic                   lsu_rsp_valid,
  input  logic                   lsu_rsp_ready,
  output logic [DTCM_RAM_DW-1:0] lsu_rsp_rdata,
  input  logic                   ext_cmd_valid,
  output logic                   ext_cmd_ready,
  input  logic                   ext_cmd_read,
  input  logic [DTCM_RAM_AW-1:0] ext_cmd_addr,
  input  logic [DTCM_RAM_MW-1:0] ext_cmd_wmask,
  input  logic [DTCM_RAM_DW-1:0] ext_cmd_wdata,
  output logic                   ext_rsp_valid,
  input  logic                   ext_rsp_ready,
  output logic [DTCM_RAM_DW-1:0] ext_rsp_rdata,
  output logic                   dtcm_ram_cs,
  output logic                   dtcm_ram_we,
  output logic [DTCM_RAM_AW-1:0] dtcm_ram_addr,
  output logic [DTCM_RAM_MW-1:0] dtcm_ram_wem,
  output logic [DTCM_RAM_DW-1:0] dtcm_ram_din,
  input  logic [DTCM_RAM_DW-1:0] dtcm_ram_dout
);

  logic rr_last_r;
  logic elig_lsu_s;
  logic elig_ext_s;
  logic grant_lsu_s;
  logic grant_ext_s;

  // A port may only issue when its response slot will be free next cycle.
  assign elig_lsu_s = lsu_cmd_valid & (~lsu_rsp_valid | lsu_rsp_ready) & ~rst;
  assign elig_ext_s = ext_cmd_valid & (~ext_rsp_valid | ext_rsp_ready) & ~rst;

  // Round-robin pick: on a tie the port not granted last time wins.
  always_comb begin
    grant_lsu_s = 1'b0;
    grant_ext_s = 1'b0;
    if (elig_lsu_s && elig_ext_s) begin
      if (rr_last_r == PORT_LSU) begin
        grant_ext_s = 1'b1;
      end else begin
        grant_lsu_s = 1'b1;
      end
    end else if (elig_lsu_s) begin
      grant_lsu_s = 1'b1;
    end else if (elig_ext_s) begin
      grant_ext_s = 1'b1;
    end else begin
      grant_lsu_s = 1'b0;
      grant_ext_s = 1'b0;
    end
  end

  // Last-granted port register for round-robin fairness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_r <= PORT_EXT;
    end else if (grant_lsu_s) begin
      rr_last_r <= PORT_LSU;
    end else if (grant_ext_s) begin
      rr_last_r <= PORT_EXT;
    end else begin
      rr_last_r <= rr_last_r;
    end
  end

  // SRAM pin mux; everything is zero on idle cycles and the byte mask is zero on reads.
  always_comb begin
    dtcm_ram_cs   = 1'b0;
    dtcm_ram_we   = 1'b0;
    dtcm_ram_addr = {DTCM_RAM_AW{1'b0}};
    dtcm_ram_wem  = {DTCM_RAM_MW{1'b0}};
    dtcm_ram_din  = {DTCM_RAM_DW{1'b0}};
    if (grant_lsu_s) begin
      dtcm_ram_cs   = 1'b1;
      dtcm_ram_we   = ~lsu_cmd_read;
      dtcm_ram_addr = lsu_cmd_addr;
      dtcm_ram_wem  = lsu_cmd_read ? {DTCM_RAM_MW{1'b0}} : lsu_cmd_wmask;
      dtcm_ram_din  = lsu_cmd_wdata;
    end else if (grant_ext_s) begin
      dtcm_ram_cs   = 1'b1;
      dtcm_ram_we   = ~ext_cmd_read;
      dtcm_ram_addr = ext_cmd_addr;
      dtcm_ram_wem  = ext_cmd_read ? {DTCM_RAM_MW{1'b0}} : ext_cmd_wmask;
      dtcm_ram_din  = ext_cmd_wdata;
    end else begin
      dtcm_ram_cs   = 1'b0;
    end
  end

  assign lsu_cmd_ready = grant_lsu_s;
  assign ext_cmd_ready = grant_ext_s;

  dtcm_rsp_slot u_lsu_slot (
    .clk        (clk),
    .rst        (rst),
    .grant      (grant_lsu_s),
    .grant_read (lsu_cmd_read),
    .rsp_ready  (lsu_rsp_ready),
    .ram_dout   (dtcm_ram_dout),
    .rsp_valid  (lsu_rsp_valid),
    .rsp_rdata  (lsu_rsp_rdata)
  );

  dtcm_rsp_slot u_ext_slot (
    .clk        (clk),
    .rst        (rst),
    .grant      (grant_ext_s),
    .grant_read (ext_cmd_read),
    .rsp_ready  (ext_rsp_ready),
    .ram_dout   (dtcm_ram_dout),
    .rsp_valid  (ext_rsp_valid),
    .rsp_rdata  (ext_rsp_rdata)
  );

endmodule

// File: tb/tb_dtcm_arbiter.sv
// Bench for dtcm_arbiter: behavioural SRAM, reference memory and per-port
// response scoreboards, plus scenario tasks with inline checks.
module tb_dtcm_arbiter;

  logic        clk;
  logic        rst;
  logic        lsu_cmd_valid, lsu_cmd_ready, lsu_cmd_read;
  logic [15:0] lsu_cmd_addr;
  logic [3:0]  lsu_cmd_wmask;
  logic [31:0] lsu_cmd_wdata;
  logic        lsu_rsp_valid, lsu_rsp_ready;
  logic [31:0] lsu_rsp_rdata;
  logic        ext_cmd_valid, ext_cmd_ready, ext_cmd_read;
  logic [15:0] ext_cmd_addr;
  logic [3:0]  ext_cmd_wmask;
  logic [31:0] ext_cmd_wdata;
  logic        ext_rsp_valid, ext_rsp_ready;
  logic [31:0] ext_rsp_rdata;
  logic        dtcm_ram_cs, dtcm_ram_we;
  logic [15:0] dtcm_ram_addr;
  logic [3:0]  dtcm_ram_wem;
  logic [31:0] dtcm_ram_din;
  logic [31:0] dtcm_ram_dout;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [0:511];
  logic [31:0] ref_mem [0:511];
  logic        pl_en;
  logic [8:0]  pl_addr;
  logic [31:0] pl_data;

  logic [31:0] lsu_q[$];
  logic [31:0] ext_q[$];
  logic        lsu_acc_d = 1'b0;
  logic        ext_acc_d = 1'b0;

  dtcm_arbiter dut (
    .clk(clk), .rst(rst),
    .lsu_cmd_valid(lsu_cmd_valid), .lsu_cmd_ready(lsu_cmd_ready), .lsu_cmd_read(lsu_cmd_read),
    .lsu_cmd_addr(lsu_cmd_addr), .lsu_cmd_wmask(lsu_cmd_wmask), .lsu_cmd_wdata(lsu_cmd_wdata),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
    .ext_cmd_valid(ext_cmd_valid), .ext_cmd_ready(ext_cmd_ready), .ext_cmd_read(ext_cmd_read),
    .ext_cmd_addr(ext_cmd_addr), .ext_cmd_wmask(ext_cmd_wmask), .ext_cmd_wdata(ext_cmd_wdata),
    .ext_rsp_valid(ext_rsp_valid), .ext_rsp_ready(ext_rsp_ready), .ext_rsp_rdata(ext_rsp_rdata),
    .dtcm_ram_cs(dtcm_ram_cs), .dtcm_ram_we(dtcm_ram_we), .dtcm_ram_addr(dtcm_ram_addr),
    .dtcm_ram_wem(dtcm_ram_wem), .dtcm_ram_din(dtcm_ram_din), .dtcm_ram_dout(dtcm_ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port SRAM with byte mask and a preload path.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (dtcm_ram_cs) begin
      if (dtcm_ram_we) begin
        for (int b = 0; b < 4; b++)
          if (dtcm_ram_wem[b]) mem[dtcm_ram_addr[8:0]][b*8 +: 8] <= dtcm_ram_din[b*8 +: 8];
      end else begin
        dtcm_ram_dout <= mem[dtcm_ram_addr[8:0]];
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[b*8 +: 8] = data[b*8 +: 8];
    return r;
  endfunction

  // Scoreboard: expectations pushed on command handshake, compared every response-valid cycle.
  always @(negedge clk) begin
    if (rst) begin
      lsu_q.delete();
      ext_q.delete();
      lsu_acc_d = 1'b0;
      ext_acc_d = 1'b0;
    end else begin
      if (lsu_acc_d) begin
        checks++;
        if (lsu_rsp_valid !== 1'b1) begin
          errors++;
          $display("FAIL lsu_latency: rsp_valid=%b expected 1", lsu_rsp_valid);
        end
      end
      if (ext_acc_d) begin
        checks++;
        if (ext_rsp_valid !== 1'b1) begin
          errors++;
          $display("FAIL ext_latency: rsp_valid=%b expected 1", ext_rsp_valid);
        end
      end
      if (lsu_rsp_valid) begin
        checks++;
        if (lsu_q.size() == 0) begin
          errors++;
          $display("FAIL lsu_rsp_unexpected: rdata=%h with no outstanding command", lsu_rsp_rdata);
        end else begin
          if (lsu_rsp_rdata !== lsu_q[0]) begin
            errors++;
            $display("FAIL lsu_rsp_rdata: got %h expected %h", lsu_rsp_rdata, lsu_q[0]);
          end
          if (lsu_rsp_ready) void'(lsu_q.pop_front());
        end
      end
      if (ext_rsp_valid) begin
        checks++;
        if (ext_q.size() == 0) begin
          errors++;
          $display("FAIL ext_rsp_unexpected: rdata=%h with no outstanding command", ext_rsp_rdata);
        end else begin
          if (ext_rsp_rdata !== ext_q[0]) begin
            errors++;
            $display("FAIL ext_rsp_rdata: got %h expected %h", ext_rsp_rdata, ext_q[0]);
          end
          if (ext_rsp_ready) void'(ext_q.pop_front());
        end
      end
      lsu_acc_d = lsu_cmd_valid && lsu_cmd_ready;
      ext_acc_d = ext_cmd_valid && ext_cmd_ready;
      if (lsu_acc_d) begin
        lsu_q.push_back(lsu_cmd_read ? ref_mem[lsu_cmd_addr[8:0]] : 32'h0);
        if (!lsu_cmd_read)
          ref_mem[lsu_cmd_addr[8:0]] = merge(ref_mem[lsu_cmd_addr[8:0]], lsu_cmd_wdata, lsu_cmd_wmask);
      end
      if (ext_acc_d) begin
        ext_q.push_back(ext_cmd_read ? ref_mem[ext_cmd_addr[8:0]] : 32'h0);
        if (!ext_cmd_read)
          ref_mem[ext_cmd_addr[8:0]] = merge(ref_mem[ext_cmd_addr[8:0]], ext_cmd_wdata, ext_cmd_wmask);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    lsu_cmd_valid = 1'b0;
    ext_cmd_valid = 1'b0;
    lsu_rsp_ready = 1'b1;
    ext_rsp_ready = 1'b1;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic preload();
    for (int i = 0; i < 512; i++) begin
      pl_en   = 1'b1;
      pl_addr = i[8:0];
      if (i == 4) pl_data = 32'h1234_5678;
      else if (i == 32) pl_data = 32'hAAAA_AAAA;
      else pl_data = 32'hC0DE_0000 + i;
      ref_mem[i] = pl_data;
      cyc();
    end
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b0; lsu_cmd_addr = 16'h0033;
    lsu_cmd_wmask = 4'hF; lsu_cmd_wdata = 32'h5555_5555;
    ext_cmd_valid = 1'b1; ext_cmd_read = 1'b1; ext_cmd_addr = 16'h0044;
    @(negedge clk);
    checks++;
    if ({lsu_cmd_ready, ext_cmd_ready, dtcm_ram_cs, dtcm_ram_we} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: ready/cs/we=%b expected 0000",
               {lsu_cmd_ready, ext_cmd_ready, dtcm_ram_cs, dtcm_ram_we});
    end
    checks++;
    if ({lsu_rsp_valid, ext_rsp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_rsp_valid: got %b expected 00", {lsu_rsp_valid, ext_rsp_valid});
    end
    checks++;
    if ({dtcm_ram_addr, dtcm_ram_wem, dtcm_ram_din} !== 52'h0) begin
      errors++;
      $display("FAIL reset_sram_bus: addr=%h wem=%h din=%h expected 0", dtcm_ram_addr, dtcm_ram_wem, dtcm_ram_din);
    end
    checks++;
    if ({lsu_rsp_rdata, ext_rsp_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata: lsu=%h ext=%h expected 0", lsu_rsp_rdata, ext_rsp_rdata);
    end
    lsu_cmd_valid = 1'b0; ext_cmd_valid = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_write_read();
    lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b0; lsu_cmd_addr = 16'h0010;
    lsu_cmd_wmask = 4'hF; lsu_cmd_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({lsu_cmd_ready, dtcm_ram_cs, dtcm_ram_we, dtcm_ram_addr, dtcm_ram_wem, dtcm_ram_din}
        !== {3'b111, 16'h0010, 4'hF, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL wr_drive: ready/cs/we=%b addr=%h wem=%h din=%h expected 111 0010 f deadbeef",
               {lsu_cmd_ready, dtcm_ram_cs, dtcm_ram_we}, dtcm_ram_addr, dtcm_ram_wem, dtcm_ram_din);
    end
    cyc();
    lsu_cmd_read = 1'b1;
    @(negedge clk);
    checks++;
    if ({dtcm_ram_cs, dtcm_ram_we, dtcm_ram_wem} !== 6'b10_0000) begin
      errors++;
      $display("FAIL rd_drive: cs/we=%b wem=%h expected 10 0", {dtcm_ram_cs, dtcm_ram_we}, dtcm_ram_wem);
    end
    checks++;
    if (lsu_rsp_valid !== 1'b1 || lsu_rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL wr_ack: valid=%b rdata=%h expected 1 00000000", lsu_rsp_valid, lsu_rsp_rdata);
    end
    cyc();
    lsu_cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dtcm_ram_cs !== 1'b0 || lsu_rsp_valid !== 1'b1 || lsu_rsp_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_data: cs=%b valid=%b rdata=%h expected 0 1 deadbeef",
               dtcm_ram_cs, lsu_rsp_valid, lsu_rsp_rdata);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (lsu_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_done: valid=%b expected 0", lsu_rsp_valid);
    end
    idle(2);
  endtask

  task automatic test_round_robin();
    logic exp_lsu;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b1; lsu_cmd_addr = 16'h0100;
    ext_cmd_valid = 1'b1; ext_cmd_read = 1'b1; ext_cmd_addr = 16'h0180;
    for (int k = 0; k < 4; k++) begin
      exp_lsu = (k % 2 == 0);
      @(negedge clk);
      checks++;
      if ({lsu_cmd_ready, ext_cmd_ready, dtcm_ram_cs} !== {exp_lsu, ~exp_lsu, 1'b1}) begin
        errors++;
        $display("FAIL rr_grant[%0d]: lsu/ext/cs=%b expected %b", k,
                 {lsu_cmd_ready, ext_cmd_ready, dtcm_ram_cs}, {exp_lsu, ~exp_lsu, 1'b1});
      end
      cyc();
      if (exp_lsu) lsu_cmd_addr = lsu_cmd_addr + 16'd1;
      else ext_cmd_addr = ext_cmd_addr + 16'd1;
    end
    idle(3);
  endtask

  task automatic test_backpressure();
    lsu_rsp_ready = 1'b0;
    lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b1; lsu_cmd_addr = 16'h0004;
    @(negedge clk);
    checks++;
    if (lsu_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_grant: ready=%b expected 1", lsu_cmd_ready);
    end
    cyc();
    lsu_cmd_addr = 16'h0005;
    ext_cmd_valid = 1'b1; ext_cmd_read = 1'b1; ext_cmd_addr = 16'h0040;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({lsu_rsp_valid, lsu_cmd_ready, ext_cmd_ready} !== 3'b101 || lsu_rsp_rdata !== 32'h1234_5678) begin
        errors++;
        $display("FAIL bp_stall[%0d]: valid/lsu_rdy/ext_rdy=%b rdata=%h expected 101 12345678",
                 k, {lsu_rsp_valid, lsu_cmd_ready, ext_cmd_ready}, lsu_rsp_rdata);
      end
      cyc();
      ext_cmd_addr = ext_cmd_addr + 16'd1;
    end
    lsu_rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({lsu_cmd_ready, ext_cmd_ready} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release: lsu/ext ready=%b expected 10", {lsu_cmd_ready, ext_cmd_ready});
    end
    cyc();
    idle(3);
  endtask

  task automatic test_back_to_back();
    lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      lsu_cmd_addr = k[15:0];
      @(negedge clk);
      checks++;
      if (lsu_cmd_ready !== 1'b1 || lsu_rsp_valid !== (k != 0)) begin
        errors++;
        $display("FAIL b2b[%0d]: ready=%b rsp_valid=%b expected 1 %b", k, lsu_cmd_ready, lsu_rsp_valid, k != 0);
      end
      cyc();
    end
    lsu_cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (lsu_rsp_valid !== 1'b1 || lsu_rsp_rdata !== 32'hC0DE_0003) begin
      errors++;
      $display("FAIL b2b_last: valid=%b rdata=%h expected 1 c0de0003", lsu_rsp_valid, lsu_rsp_rdata);
    end
    cyc();
    idle(2);
  endtask

  task automatic test_async_reset();
    ext_rsp_ready = 1'b0;
    ext_cmd_valid = 1'b1; ext_cmd_read = 1'b1; ext_cmd_addr = 16'h0007;
    @(negedge clk);
    cyc();
    ext_cmd_valid = 1'b0;
    checks++;
    if (ext_rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL ar_inflight: ext_rsp_valid=%b expected 1", ext_rsp_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ext_rsp_valid !== 1'b0 || ext_rsp_rdata !== 32'h0 || dtcm_ram_cs !== 1'b0) begin
      errors++;
      $display("FAIL ar_async: valid=%b rdata=%h cs=%b expected 0 0 0", ext_rsp_valid, ext_rsp_rdata, dtcm_ram_cs);
    end
    cyc();
    rst = 1'b0;
    ext_rsp_ready = 1'b1;
    lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b1; lsu_cmd_addr = 16'h0008;
    ext_cmd_valid = 1'b1; ext_cmd_addr = 16'h0009;
    @(negedge clk);
    checks++;
    if ({lsu_cmd_ready, ext_cmd_ready} !== 2'b10) begin
      errors++;
      $display("FAIL ar_first_tie: lsu/ext ready=%b expected 10", {lsu_cmd_ready, ext_cmd_ready});
    end
    cyc();
    idle(3);
  endtask

  task automatic test_wmask();
    lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b0; lsu_cmd_addr = 16'h0020;
    lsu_cmd_wmask = 4'h3; lsu_cmd_wdata = 32'h0000_BBBB;
    @(negedge clk);
    checks++;
    if (dtcm_ram_wem !== 4'h3 || dtcm_ram_we !== 1'b1) begin
      errors++;
      $display("FAIL wm_write: wem=%h we=%b expected 3 1", dtcm_ram_wem, dtcm_ram_we);
    end
    cyc();
    lsu_cmd_read = 1'b1;
    @(negedge clk);
    checks++;
    if (dtcm_ram_wem !== 4'h0 || dtcm_ram_we !== 1'b0) begin
      errors++;
      $display("FAIL wm_read_wem: wem=%h we=%b expected 0 0", dtcm_ram_wem, dtcm_ram_we);
    end
    cyc();
    lsu_cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (lsu_rsp_valid !== 1'b1 || lsu_rsp_rdata !== 32'hAAAA_BBBB) begin
      errors++;
      $display("FAIL wm_readback: valid=%b rdata=%h expected 1 aaaabbbb", lsu_rsp_valid, lsu_rsp_rdata);
    end
    cyc();
    idle(2);
  endtask

  initial begin
    rst = 1'b1;
    pl_en = 1'b0; pl_addr = 9'h0; pl_data = 32'h0;
    lsu_cmd_valid = 1'b0; lsu_cmd_read = 1'b0; lsu_cmd_addr = 16'h0;
    lsu_cmd_wmask = 4'h0; lsu_cmd_wdata = 32'h0; lsu_rsp_ready = 1'b1;
    ext_cmd_valid = 1'b0; ext_cmd_read = 1'b0; ext_cmd_addr = 16'h0;
    ext_cmd_wmask = 4'h0; ext_cmd_wdata = 32'h0; ext_rsp_ready = 1'b1;
    preload();
    test_reset();
    test_write_read();
    test_round_robin();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_wmask();
    idle(2);
    checks++;
    if (lsu_q.size() != 0 || ext_q.size() != 0) begin
      errors++;
      $display("FAIL drain: outstanding lsu=%0d ext=%0d expected 0 0", lsu_q.size(), ext_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dtcm_arbiter.md
Name: dtcm_arbiter

Overview:
- Shares the single-port DTCM SRAM between two requesters: the LSU (port 0) and the external system-bus/debug access port (port 1).
- Arbitrates the two valid/ready command channels round-robin and drives the SRAM control pins.
- Tracks the 1-cycle synchronous SRAM read latency and returns read data and write acks on per-port valid/ready response channels, each with a 1-entry hold buffer.
- Sits between lsu/ext-bus and the dtcm_ram instance.

Parameters:
- DTCM_RAM_AW, 16: SRAM word-address width.
- DTCM_RAM_DW, 32: SRAM data width.
- DTCM_RAM_MW, 4: write byte-mask width (DW/8).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- lsu_cmd_valid / lsu_cmd_ready  in/out  1  LSU command handshake.
- lsu_cmd_read  in  1  1=read, 0=write.
- lsu_cmd_addr  in  AW  word address.
- lsu_cmd_wmask  in  MW  byte write mask.
- lsu_cmd_wdata  in  DW  write data.
- lsu_rsp_valid / lsu_rsp_ready  out/in  1  LSU response handshake.
- lsu_rsp_rdata  out  DW  read data; 0 for write acks.
- ext_cmd_valid, ext_cmd_ready, ext_cmd_read, ext_cmd_addr, ext_cmd_wmask, ext_cmd_wdata, ext_rsp_valid, ext_rsp_ready, ext_rsp_rdata: same widths and meaning for the external port.
- dtcm_ram_cs  out  1  SRAM chip select; access this cycle.
- dtcm_ram_we  out  1  write enable, qualified by cs.
- dtcm_ram_addr  out  AW  SRAM address.
- dtcm_ram_wem  out  MW  byte write-enable mask.
- dtcm_ram_din  out  DW  SRAM write data.
- dtcm_ram_dout  in  DW  SRAM read data, valid one cycle after a cs&~we access.

Behaviour:
- Eligibility: port p is eligible when p_cmd_valid & (~p_rsp_valid | p_rsp_ready), i.e. its response slot is free next cycle.
- Arbitration: combinational round-robin among eligible ports. Register rr_last holds the last granted port; the other port wins a tie. Reset value of rr_last = 1, so the LSU wins the first tie.
- Grant: p_cmd_ready = grant_p, at most one per cycle. Handshake completes in the same cycle (cmd valid & ready).
- SRAM drive on a granted cycle: dtcm_ram_cs=1, we=~read, addr/wem/din from the winner.
- Idle cycles: cs=0, we=0, addr/wem/din=0. wem is forced to 0 on reads.
- Per-port response state (flops): rsp_vld_p, fresh_p (data comes from SRAM this cycle), is_rd_p, hold_p[DW].
- Cycle after grant: rsp_vld_p=1, fresh_p=1. rdata = is_rd_p ? dtcm_ram_dout : 0.
- Not accepted while fresh: capture rdata into hold_p and clear fresh_p. Later cycles present hold_p until p_rsp_ready.
- Accepted with no new grant: rsp_vld_p clears the next cycle.
- Accepted with a same-cycle new grant to p: rsp_vld_p stays 1 and fresh_p=1. This gives full throughput, 1 access per cycle.
- Latency: command accept to rsp_valid is exactly 1 cycle.
- Ordering: in order per port. The ports are independent; the LSU can stall its response without blocking ext.
- Back-pressure: a port with rsp_valid=1 and rsp_ready=0 is ineligible. The other port keeps full access.
- Only one port valid: it is granted every eligible cycle regardless of rr_last.
- rsp_valid stays asserted, with rdata stable, until the handshake completes.
- Reset (async, any time, including mid-transaction): rsp_vld_*=0, fresh_*=0, is_rd_*=0, hold_*=0, rr_last=1. In-flight reads are dropped.
  - All outputs read 0 during reset. cmd_ready is 0 during reset because cs requires ~rst.
  - An in-flight SRAM write may or may not have completed; that is the system's responsibility.

Decomposition:
- Shared package/defines: DTCM_RAM_AW/DW/MW and the port index constants (PORT_LSU=0, PORT_EXT=1).
- One sub-module, dtcm_rsp_slot, instantiated per port. It holds rsp_vld, fresh, is_rd and hold, and does the dout bypass/capture mux.
- The arbiter, rr_last and SRAM mux live in the top.

Test Plan:
- LSU write addr 0x0010, wdata 0xDEADBEEF, wmask 0xF, then read 0x0010, rsp_ready=1 → cs pulses on 2 consecutive cycles. Write ack rdata=0 at T+1; read rdata=0xDEADBEEF at T+2.
- Both ports valid every cycle, reads of distinct addresses, rsp_ready=1 → grants after reset: LSU, EXT, LSU, EXT. No cycle has cs=0.
- LSU read 0x0004 (mem=0x12345678) with lsu_rsp_ready=0 for 5 cycles → rdata holds 0x12345678 all 5 cycles. LSU ungranted; ext streams 5 grants meanwhile.
- LSU back-to-back reads 0x0..0x3 with rsp_ready=1 → 4 consecutive grants. Responses on 4 consecutive cycles in order.
- Assert rst while an ext read is in flight → ext_rsp_valid=0 immediately (async). After release, first tie goes to LSU.
- Write with wmask 0x3 over 0xAAAAAAAA, data 0x0000BBBB → read back 0xAAAABBBB. dtcm_ram_wem=0 on the read cycle.
